// File: rtl/multiplexador_pipeline.sv
// Registered N-way word select feeding a 2-entry elastic buffer (head + skid).
// The select can be locked to the last unlocked select; out-of-range selects yield a zero word with err set.
module multiplexador_pipeline #(
   parameter int WIDTH    = 5,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      lock,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_sel,
   output logic                      out_err,
   output logic                      out_valid,
   input  logic                      out_ready
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [SEL_W-1:0] lock_sel_q, lock_sel_d;
   logic [WIDTH-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;
   logic [SEL_W-1:0] head_sel_q, head_sel_d, skid_sel_q, skid_sel_d;
   logic             head_err_q, head_err_d, skid_err_q, skid_err_d;

   logic [WIDTH-1:0] chan [CHANNELS];
   logic [SEL_W-1:0] eff_sel;
   logic [WIDTH-1:0] new_word;
   logic             new_err;
   logic             accept, emit;

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
         assign chan[gi] = in_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Selects with no matching channel fall through to the zero default.
   always_comb begin
      eff_sel  = lock ? lock_sel_q : sel;
      new_err  = (32'(eff_sel) >= 32'(CHANNELS));
      new_word = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (eff_sel == SEL_W'(i)) new_word = chan[i];
      end
   end

   assign in_ready = (state_q != ST_TWO);
   assign accept   = in_valid && in_ready;
   assign emit     = out_valid_q && out_ready;

   always_comb begin
      state_d     = state_q;
      head_data_d = head_data_q;
      head_sel_d  = head_sel_q;
      head_err_d  = head_err_q;
      skid_data_d = skid_data_q;
      skid_sel_d  = skid_sel_q;
      skid_err_d  = skid_err_q;
      lock_sel_d  = (accept && !lock) ? sel : lock_sel_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               head_data_d = new_word;
               head_sel_d  = eff_sel;
               head_err_d  = new_err;
               state_d     = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && emit) begin
               head_data_d = new_word;
               head_sel_d  = eff_sel;
               head_err_d  = new_err;
            end else if (accept) begin
               skid_data_d = new_word;
               skid_sel_d  = eff_sel;
               skid_err_d  = new_err;
               state_d     = ST_TWO;
            end else if (emit) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (emit) begin
               head_data_d = skid_data_q;
               head_sel_d  = skid_sel_q;
               head_err_d  = skid_err_q;
               state_d     = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      out_valid_d = (state_d != ST_EMPTY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         out_valid_q <= 1'b0;
         lock_sel_q  <= '0;
         head_data_q <= '0;
         head_sel_q  <= '0;
         head_err_q  <= 1'b0;
         skid_data_q <= '0;
         skid_sel_q  <= '0;
         skid_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         lock_sel_q  <= lock_sel_d;
         head_data_q <= head_data_d;
         head_sel_q  <= head_sel_d;
         head_err_q  <= head_err_d;
         skid_data_q <= skid_data_d;
         skid_sel_q  <= skid_sel_d;
         skid_err_q  <= skid_err_d;
      end
   end

   assign out_data  = head_data_q;
   assign out_sel   = head_sel_q;
   assign out_err   = head_err_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplexador_pipeline.sv
// Bench for multiplexador_pipeline: a 4-channel and a 3-channel instance share stimulus,
// each checked every cycle against a queue-based model, plus directed literal checks.
module tb_multiplexador_pipeline;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [19:0] in_data = '0;
   logic [1:0]  sel = '0;
   logic        lock = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;

   logic        a_in_ready, a_out_err, a_out_valid;
   logic [4:0]  a_out_data;
   logic [1:0]  a_out_sel;
   logic        b_in_ready, b_out_err, b_out_valid;
   logic [4:0]  b_out_data;
   logic [1:0]  b_out_sel;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   multiplexador_pipeline #(.WIDTH(5), .CHANNELS(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .lock(lock),
      .in_valid(in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
      .out_sel(a_out_sel), .out_err(a_out_err), .out_valid(a_out_valid),
      .out_ready(out_ready)
   );

   multiplexador_pipeline #(.WIDTH(5), .CHANNELS(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(in_data[14:0]), .sel(sel), .lock(lock),
      .in_valid(in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
      .out_sel(b_out_sel), .out_err(b_out_err), .out_valid(b_out_valid),
      .out_ready(out_ready)
   );

   typedef struct packed {
      logic [4:0] d;
      logic [1:0] s;
      logic       e;
   } beat_t;

   beat_t      mqa[$];
   beat_t      mqb[$];
   logic [1:0] la = '0;
   logic [1:0] lb = '0;

   function automatic beat_t make_beat(logic [19:0] d, int ch, logic [1:0] s);
      beat_t b;
      b.s = s;
      b.e = (int'(s) >= ch);
      b.d = b.e ? 5'd0 : d[int'(s)*5 +: 5];
      return b;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a FIFO of depth 2; emit pops the head before accept pushes.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mqa.delete();
         mqb.delete();
         la = '0;
         lb = '0;
      end else begin
         automatic bit acc_a = in_valid && (mqa.size() < 2);
         automatic bit emi_a = (mqa.size() > 0) && out_ready;
         automatic bit acc_b = in_valid && (mqb.size() < 2);
         automatic bit emi_b = (mqb.size() > 0) && out_ready;
         automatic logic [1:0] ea = lock ? la : sel;
         automatic logic [1:0] eb = lock ? lb : sel;
         if (emi_a) void'(mqa.pop_front());
         if (acc_a) mqa.push_back(make_beat(in_data, 4, ea));
         if (acc_a && !lock) la = sel;
         if (emi_b) void'(mqb.pop_front());
         if (acc_b) mqb.push_back(make_beat({5'd0, in_data[14:0]}, 3, eb));
         if (acc_b && !lock) lb = sel;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("a_in_ready", a_in_ready, mqa.size() < 2);
         chk("a_out_valid", a_out_valid, mqa.size() > 0);
         if (mqa.size() > 0) begin
            chk("a_out_data", a_out_data, mqa[0].d);
            chk("a_out_sel", a_out_sel, mqa[0].s);
            chk("a_out_err", a_out_err, mqa[0].e);
         end
         chk("b_in_ready", b_in_ready, mqb.size() < 2);
         chk("b_out_valid", b_out_valid, mqb.size() > 0);
         if (mqb.size() > 0) begin
            chk("b_out_data", b_out_data, mqb[0].d);
            chk("b_out_sel", b_out_sel, mqb[0].s);
            chk("b_out_err", b_out_err, mqb[0].e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      in_data   = {5'h1F, 5'h15, 5'h0A, 5'h01};
      sel       = 2'd2;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #2;
      chk("reset_out_valid", a_out_valid, 0);
      chk("reset_out_data", a_out_data, 0);
      chk("reset_out_sel", a_out_sel, 0);
      chk("reset_out_err", a_out_err, 0);
      chk("reset_in_ready", a_in_ready, 1);
      #1 rst_n = 1'b1;

      // basic select: first edge accepts sel=2
      step();
      chk("basic_data", a_out_data, 5'h15);
      chk("basic_sel", a_out_sel, 2);
      chk("basic_err", a_out_err, 0);
      chk("basic_valid", a_out_valid, 1);
      in_valid = 1'b0;
      step();

      // backpressure
      out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
      step();
      sel = 2'd1;
      step();
      chk("bp_in_ready_full", a_in_ready, 0);
      chk("bp_head", a_out_data, 5'h01);
      sel = 2'd3;
      step();
      chk("bp_head_stable", a_out_data, 5'h01);
      chk("bp_b_head_stable", b_out_data, 5'h01);
      out_ready = 1'b1;
      step();
      chk("bp_second", a_out_data, 5'h0A);
      step();
      chk("bp_third", a_out_data, 5'h1F);
      chk("oor_b_data", b_out_data, 0);
      chk("oor_b_err", b_out_err, 1);
      chk("oor_b_sel", b_out_sel, 3);
      in_valid = 1'b0;
      step();
      chk("bp_drained", a_out_valid, 0);

      // lock mode
      in_valid = 1'b1; sel = 2'd1; lock = 1'b0;
      step();
      lock = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sel = (i == 0) ? 2'd3 : (i == 1) ? 2'd0 : 2'd2;
         step();
         chk("lock_data", a_out_data, 5'h0A);
         chk("lock_sel", a_out_sel, 1);
      end
      lock = 1'b0; sel = 2'd3;
      step();
      chk("unlock_data", a_out_data, 5'h1F);
      chk("unlock_sel", a_out_sel, 3);
      chk("unlock_b_err", b_out_err, 1);
      sel = 2'd2;
      step();
      chk("b_inrange_err", b_out_err, 0);
      chk("b_inrange_data", b_out_data, 5'h15);

      // back-to-back
      for (int i = 0; i < 10; i++) begin
         sel = 2'($urandom);
         in_data = 20'($urandom);
         step();
         chk("b2b_in_ready", a_in_ready, 1);
         chk("b2b_out_valid", a_out_valid, 1);
      end

      // asynchronous reset while TWO
      in_valid = 1'b0;
      step();
      out_ready = 1'b0; in_valid = 1'b1;
      step();
      step();
      chk("pre_rst_in_ready", a_in_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_out_data", a_out_data, 0);
      in_valid = 1'b0; out_ready = 1'b1;
      #3 rst_n = 1'b1;
      step();
      chk("post_rst_no_stale", a_out_valid, 0);
      chk("post_rst_b_no_stale", b_out_valid, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         in_data   = 20'($urandom);
         sel       = 2'($urandom);
         lock      = ($urandom_range(0, 3) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 6);
         step();
      end
      in_valid = 1'b0;
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multiplexador_pipeline.md
# multiplexador_pipeline

Parametrised, registered N-way select block for the datapath: the general successor of the fixed 2:1 combinational register-destination mux. It chooses one of CHANNELS packed input words per beat and passes it downstream through a 2-entry elastic buffer with valid/ready handshakes on both sides. It also supports a select-lock mode that reuses the last accepted select, and flags out-of-range selects. It sits between the decode-stage operand sources and the next pipeline register, so that upstream stalls and downstream stalls are decoupled.

## Interface
- WIDTH, 5, bits per channel word
- CHANNELS, 4, number of input channels (2..16, need not be a power of two)
- SEL_W, $clog2(CHANNELS) (minimum 1), select width
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous and active-low
- in_data  input  CHANNELS*WIDTH  packed channels; channel i is in_data[i*WIDTH +: WIDTH]
- sel  input  SEL_W  channel select for this beat
- lock  input  1  1 = ignore sel and use the locked select
- in_valid  input  1  upstream beat present
- in_ready  output  1  block can accept a beat
- out_data  output  WIDTH  selected word
- out_sel  output  SEL_W  effective select used for out_data
- out_err  output  1  beat's effective select was >= CHANNELS
- out_valid  output  1  output beat present
- out_ready  input  1  downstream accepts

## Operation
- Accept condition: in_valid && in_ready. Emit condition: out_valid && out_ready.
- Effective select:
  - eff_sel = lock ? lock_sel : sel.
  - On every accept with lock=0, lock_sel <= sel.
  - With lock=1, lock_sel is unchanged.
- Out-of-range select (eff_sel >= CHANNELS): the stored word is all-zero and the stored err bit is 1. The beat is still accepted and emitted, never dropped.
- Each beat stores the triple {word, eff_sel, err}. The output ports always show the head entry.
- Buffer states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: head valid, in_ready=1.
  - TWO: head plus skid entry, in_ready=0.
- Transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept without emit -> TWO. Emit without accept -> EMPTY. Accept and emit together -> ONE, and the new beat becomes head.
  - TWO: emit -> ONE, and the skid entry moves to head. No accept is possible in TWO.
- Ordering is strictly FIFO; beats are never duplicated or lost.
- in_ready is a function of registered state only, with no combinational path from out_ready. out_data, out_sel, out_err and out_valid come straight from registers.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_sel and out_err hold their values.
- Unselected channels, and sel while lock=1, have no effect.

## Timing
- Reset (rst_n=0, any time, asynchronous):
  - State becomes EMPTY.
  - out_valid=0, out_data=0, out_sel=0, out_err=0, lock_sel=0, in_ready=1.
  - Any in-flight beats are discarded.
  - The first accept is possible on the first rising edge after rst_n deasserts.
- Latency: a beat accepted at edge k is on the outputs with out_valid=1 from just after edge k, so it can be emitted at edge k+1.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- A single out_ready low cycle moves the block to TWO and costs no bubble upstream until the following cycle.
- lock_sel updated at edge k applies to beats presented from cycle k+1 onward. The beat accepted at edge k itself uses the pre-edge value.

## Test plan
- Reset and basic select:
  - Stimulus: WIDTH=5, CHANNELS=4, in_data={4'd...: ch0=5'h01, ch1=5'h0A, ch2=5'h15, ch3=5'h1F}, sel=2, in_valid=1, out_ready=1.
  - Required: out_data=5'h15, out_sel=2, out_err=0 one cycle after the accept. Before the first edge all outputs are 0 and in_ready=1.
- Backpressure:
  - Stimulus: out_ready=0 while 3 beats are offered with sel=0,1,3.
  - Required: first two accepted, in_ready=0 after the second, head holds 5'h01 stable.
  - Then raise out_ready: emitted order 5'h01, 5'h0A, then 5'h1F is accepted and emitted. No loss.
- Lock mode:
  - Stimulus: accept with sel=1, lock=0; then 3 beats with lock=1 and sel=3,0,2.
  - Required: all three emit ch1 (5'h0A) with out_sel=1.
  - Then lock=0, sel=3 -> 5'h1F.
- Out-of-range:
  - Stimulus: CHANNELS=3, sel=3.
  - Required: out_data=0, out_err=1, out_sel=3. The next beat with sel=2 shows out_err=0.
- Simultaneous accept/emit in ONE:
  - Stimulus: 10 back-to-back beats with out_ready=1.
  - Required: state stays ONE, 10 emits in 10 cycles, in_ready constantly 1.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously while in TWO.
  - Required: out_valid drops immediately, in_ready=1, and no stale beat appears after release.
